// File: rtl/dmem_access_sequencer_if.sv
//------------------------------------------------------------------------------
// dmem_access_sequencer_if : request, data-RAM and controller signal bundle
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface dmem_access_sequencer_if #(
    parameter int ADDR_W = 10
);
    logic              Req_valid;
    logic              Req_ready;
    logic              Req_write;
    logic [31:0]       Req_addr;
    logic [2:0]        Req_type;
    logic              Ram_en;
    logic              Ram_we;
    logic [ADDR_W-1:0] Ram_addr;
    logic [31:0]       Ram_wdata;
    logic [31:0]       Ram_rdata;
    logic [1:0]        Mc_addr_lo;
    logic [2:0]        Mc_type;
    logic [31:0]       Mc_rdata;
    logic [31:0]       Mc_wdata;
    logic [31:0]       Load_data;
    logic              Done;
    logic              Err;

    modport slave (
        input  Req_valid, Req_write, Req_addr, Req_type, Ram_rdata, Mc_rdata, Mc_wdata,
        output Req_ready, Ram_en, Ram_we, Ram_addr, Ram_wdata, Mc_addr_lo, Mc_type,
               Load_data, Done, Err
    );

    modport master (
        output Req_valid, Req_write, Req_addr, Req_type, Ram_rdata, Mc_rdata, Mc_wdata,
        input  Req_ready, Ram_en, Ram_we, Ram_addr, Ram_wdata, Mc_addr_lo, Mc_type,
               Load_data, Done, Err
    );
endinterface

`default_nettype wire

// File: rtl/dmem_access_sequencer.sv
//------------------------------------------------------------------------------
// dmem_access_sequencer : load/store sequencer for the data RAM and extract/merge stage
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dmem_access_sequencer #(
    parameter int ADDR_W = 10
) (
    input  wire logic              Clk,
    input  wire logic              Rst_n,
    dmem_access_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_WRITE   = 3'd4,
        S_ERR     = 3'd5
    } state_t;

    state_t            r_state;
    logic              r_write;
    logic              r_req_ready;
    logic              r_ram_en;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [31:0]       r_wdata;
    logic [1:0]        r_mc_addr_lo;
    logic [2:0]        r_mc_type;
    logic [31:0]       r_load_data;
    logic              r_done;
    logic              r_err;

    logic [1:0]        w_lane;
    logic              w_reject;
    logic              w_unused_addr_hi;

    assign w_unused_addr_hi = ^bus.Req_addr[31:ADDR_W+2];

    always_comb begin
        w_lane   = bus.Req_addr[1:0];
        w_reject = 1'b0;
        case (bus.Req_type[1:0])
            2'b01: begin
                w_lane   = {1'b0, bus.Req_addr[1]};
                w_reject = bus.Req_addr[0];
            end
            2'b10: begin
                w_lane   = 2'b00;
                w_reject = (bus.Req_addr[1:0] != 2'b00);
            end
            2'b11: begin
                w_lane   = 2'b00;
                w_reject = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state      <= S_IDLE;
            r_write      <= 1'b0;
            r_req_ready  <= 1'b1;
            r_ram_en     <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_wdata      <= '0;
            r_mc_addr_lo <= 2'b00;
            r_mc_type    <= 3'b000;
            r_load_data  <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.Req_valid) begin
                        r_write      <= bus.Req_write;
                        r_ram_addr   <= bus.Req_addr[ADDR_W+1:2];
                        r_mc_addr_lo <= w_lane;
                        r_mc_type    <= bus.Req_type;
                        r_req_ready  <= 1'b0;
                        if (w_reject) begin
                            r_state <= S_ERR;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_state  <= S_ISSUE;
                            r_ram_en <= 1'b1;
                            r_ram_we <= 1'b0;
                        end
                    end
                end
                S_ERR: begin
                    r_state     <= S_IDLE;
                    r_done      <= 1'b0;
                    r_err       <= 1'b0;
                    r_req_ready <= 1'b1;
                end
                S_ISSUE: begin
                    r_state  <= S_WAIT;
                    r_ram_en <= 1'b0;
                end
                S_WAIT: begin
                    r_state <= S_CAPTURE;
                    // Loads complete in CAPTURE, so Done must already be set on entry.
                    r_done  <= !r_write;
                end
                S_CAPTURE: begin
                    if (r_write) begin
                        r_state  <= S_WRITE;
                        r_ram_en <= 1'b1;
                        r_ram_we <= 1'b1;
                        r_done   <= 1'b1;
                    end else begin
                        r_state     <= S_IDLE;
                        r_load_data <= bus.Mc_rdata;
                        r_done      <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                S_WRITE: begin
                    r_state     <= S_IDLE;
                    r_wdata     <= bus.Mc_wdata;
                    r_ram_en    <= 1'b0;
                    r_ram_we    <= 1'b0;
                    r_done      <= 1'b0;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_ram_en    <= 1'b0;
                    r_ram_we    <= 1'b0;
                    r_done      <= 1'b0;
                    r_err       <= 1'b0;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    // Controller results are only valid within their own cycle, so they bypass the hold registers.
    assign bus.Load_data  = (r_state == S_CAPTURE && !r_write) ? bus.Mc_rdata : r_load_data;
    assign bus.Ram_wdata  = (r_state == S_WRITE) ? bus.Mc_wdata : r_wdata;
    assign bus.Req_ready  = r_req_ready;
    assign bus.Ram_en     = r_ram_en;
    assign bus.Ram_we     = r_ram_we;
    assign bus.Ram_addr   = r_ram_addr;
    assign bus.Mc_addr_lo = r_mc_addr_lo;
    assign bus.Mc_type    = r_mc_type;
    assign bus.Done       = r_done;
    assign bus.Err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_dmem_access_sequencer.sv
//------------------------------------------------------------------------------
// tb_dmem_access_sequencer : directed bench with RAM and extract/merge models
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_dmem_access_sequencer;

    localparam int ADDR_W = 10;

    logic        clk;
    logic        rst_n;
    logic [31:0] store_data;
    logic [31:0] mc_word;
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    int          tests_run;
    int          tests_failed;
    int          en_count;
    int          we_count;
    int          we_in_reset;

    dmem_access_sequencer_if #(.ADDR_W(ADDR_W)) ifc ();

    dmem_access_sequencer #(.ADDR_W(ADDR_W)) dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous data RAM
    always @(posedge clk) begin
        if (ifc.Ram_en) begin
            if (ifc.Ram_we) mem[ifc.Ram_addr] = ifc.Ram_wdata;
            else            ifc.Ram_rdata <= mem[ifc.Ram_addr];
        end
    end

    // Extract/merge stage: registers the RAM word, then extends or merges
    always @(posedge clk) mc_word <= ifc.Ram_rdata;

    function automatic logic [31:0] mc_extract(logic [31:0] w, logic [1:0] lo, logic [2:0] t);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*lo +: 8];
        h = w[16*lo[0] +: 16];
        case (t[1:0])
            2'b00:   return t[2] ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   return t[2] ? {16'd0, h} : {{16{h[15]}}, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] mc_merge(logic [31:0] w, logic [31:0] sd, logic [1:0] lo, logic [2:0] t);
        logic [31:0] r;
        r = w;
        case (t[1:0])
            2'b00:   r[8*lo +: 8]      = sd[7:0];
            2'b01:   r[16*lo[0] +: 16] = sd[15:0];
            default: r = sd;
        endcase
        return r;
    endfunction

    always_comb ifc.Mc_rdata = mc_extract(mc_word, ifc.Mc_addr_lo, ifc.Mc_type);
    always_comb ifc.Mc_wdata = mc_merge(mc_word, store_data, ifc.Mc_addr_lo, ifc.Mc_type);

    always @(posedge clk) begin
        if (ifc.Ram_en) en_count++;
        if (ifc.Ram_we) we_count++;
        if (ifc.Ram_we && !rst_n) we_in_reset++;
    end

    // Drives one request and returns at the falling edge of cycle 1
    task automatic start_req(input logic wr, input logic [31:0] addr, input logic [2:0] typ);
        @(negedge clk);
        ifc.Req_valid = 1'b1;
        ifc.Req_write = wr;
        ifc.Req_addr  = addr;
        ifc.Req_type  = typ;
        @(posedge clk);
        @(negedge clk);
        ifc.Req_valid = 1'b0;
    endtask

    task automatic test_reset();
        tests_run++;
        if (ifc.Req_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_ready got %b want 1", ifc.Req_ready); end
        tests_run++;
        if ({ifc.Ram_en, ifc.Ram_we, ifc.Done, ifc.Err} !== 4'b0000) begin
            tests_failed++; $display("FAIL rst_ctl got %b want 0000", {ifc.Ram_en, ifc.Ram_we, ifc.Done, ifc.Err});
        end
        tests_run++;
        if ({ifc.Ram_addr, ifc.Ram_wdata, ifc.Mc_addr_lo, ifc.Mc_type, ifc.Load_data} !== '0) begin
            tests_failed++; $display("FAIL rst_data got addr=%h wd=%h lo=%h ty=%h ld=%h want all 0",
                ifc.Ram_addr, ifc.Ram_wdata, ifc.Mc_addr_lo, ifc.Mc_type, ifc.Load_data);
        end
    endtask

    task automatic test_load_word();
        mem[4] = 32'hDEADBEEF;
        start_req(1'b0, 32'h0000_0010, 3'b010);
        tests_run++;
        if ({ifc.Ram_en, ifc.Ram_we, ifc.Req_ready, ifc.Done} !== 4'b1000) begin
            tests_failed++; $display("FAIL lw_c1_ctl got %b want 1000", {ifc.Ram_en, ifc.Ram_we, ifc.Req_ready, ifc.Done});
        end
        tests_run++;
        if (ifc.Ram_addr !== 10'd4) begin tests_failed++; $display("FAIL lw_ram_addr got %0d want 4", ifc.Ram_addr); end
        @(negedge clk);
        tests_run++;
        if ({ifc.Ram_en, ifc.Done} !== 2'b00) begin tests_failed++; $display("FAIL lw_c2_ctl got %b want 00", {ifc.Ram_en, ifc.Done}); end
        @(negedge clk);
        tests_run++;
        if ({ifc.Done, ifc.Err} !== 2'b10) begin tests_failed++; $display("FAIL lw_c3_done got %b want 10", {ifc.Done, ifc.Err}); end
        tests_run++;
        if (ifc.Load_data !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL lw_data got %h want deadbeef", ifc.Load_data); end
        @(negedge clk);
        tests_run++;
        if ({ifc.Done, ifc.Req_ready} !== 2'b01 || ifc.Load_data !== 32'hDEADBEEF) begin
            tests_failed++; $display("FAIL lw_c4_hold got done/ready=%b ld=%h want 01 deadbeef", {ifc.Done, ifc.Req_ready}, ifc.Load_data);
        end
    endtask

    task automatic test_load_byte();
        mem[4] = 32'h80FF_1234;
        start_req(1'b0, 32'h0000_0013, 3'b000);
        tests_run++;
        if (ifc.Mc_addr_lo !== 2'd3 || ifc.Mc_type !== 3'b000) begin
            tests_failed++; $display("FAIL lb_lane got lo=%0d ty=%b want 3 000", ifc.Mc_addr_lo, ifc.Mc_type);
        end
        repeat (2) @(negedge clk);
        tests_run++;
        if (ifc.Done !== 1'b1 || ifc.Load_data !== 32'hFFFFFF80) begin
            tests_failed++; $display("FAIL lb_data got done=%b ld=%h want 1 ffffff80", ifc.Done, ifc.Load_data);
        end
        start_req(1'b0, 32'h0000_0013, 3'b100);
        tests_run++;
        if (ifc.Mc_addr_lo !== 2'd3 || ifc.Mc_type !== 3'b100) begin
            tests_failed++; $display("FAIL lbu_lane got lo=%0d ty=%b want 3 100", ifc.Mc_addr_lo, ifc.Mc_type);
        end
        repeat (2) @(negedge clk);
        tests_run++;
        if (ifc.Done !== 1'b1 || ifc.Load_data !== 32'h00000080) begin
            tests_failed++; $display("FAIL lbu_data got done=%b ld=%h want 1 00000080", ifc.Done, ifc.Load_data);
        end
    endtask

    task automatic test_store_half();
        mem[8]     = 32'h1111_2222;
        store_data = 32'h0000_ABCD;
        start_req(1'b1, 32'h0000_0022, 3'b001);
        tests_run++;
        if (ifc.Mc_addr_lo !== 2'd1 || ifc.Ram_en !== 1'b1 || ifc.Ram_we !== 1'b0 || ifc.Ram_addr !== 10'd8) begin
            tests_failed++; $display("FAIL sh_c1 got lo=%0d en=%b we=%b addr=%0d want 1 1 0 8",
                ifc.Mc_addr_lo, ifc.Ram_en, ifc.Ram_we, ifc.Ram_addr);
        end
        repeat (2) @(negedge clk);
        tests_run++;
        if ({ifc.Done, ifc.Ram_en} !== 2'b00) begin tests_failed++; $display("FAIL sh_c3 got done/en=%b want 00", {ifc.Done, ifc.Ram_en}); end
        @(negedge clk);
        tests_run++;
        if ({ifc.Ram_en, ifc.Ram_we, ifc.Done, ifc.Err} !== 4'b1110) begin
            tests_failed++; $display("FAIL sh_c4_ctl got %b want 1110", {ifc.Ram_en, ifc.Ram_we, ifc.Done, ifc.Err});
        end
        tests_run++;
        if (ifc.Ram_wdata !== 32'hABCD_2222) begin tests_failed++; $display("FAIL sh_wdata got %h want abcd2222", ifc.Ram_wdata); end
        @(negedge clk);
        tests_run++;
        if (ifc.Ram_we !== 1'b0 || ifc.Done !== 1'b0 || mem[8] !== 32'hABCD_2222) begin
            tests_failed++; $display("FAIL sh_after got we=%b done=%b mem=%h want 0 0 abcd2222", ifc.Ram_we, ifc.Done, mem[8]);
        end
    endtask

    task automatic test_reject();
        int en_before;
        logic [31:0] addrs [3];
        logic [2:0]  types [3];
        addrs = '{32'h6, 32'h5, 32'h0};
        types = '{3'b010, 3'b001, 3'b011};
        en_before = en_count;
        for (int i = 0; i < 3; i++) begin
            start_req(1'b0, addrs[i], types[i]);
            tests_run++;
            if ({ifc.Done, ifc.Err, ifc.Ram_en} !== 3'b110) begin
                tests_failed++; $display("FAIL rej%0d_c1 got done/err/en=%b want 110", i, {ifc.Done, ifc.Err, ifc.Ram_en});
            end
            @(negedge clk);
            tests_run++;
            if ({ifc.Done, ifc.Err, ifc.Req_ready} !== 3'b001) begin
                tests_failed++; $display("FAIL rej%0d_c2 got done/err/ready=%b want 001", i, {ifc.Done, ifc.Err, ifc.Req_ready});
            end
        end
        tests_run++;
        if (en_count !== en_before) begin tests_failed++; $display("FAIL rej_ram_en got %0d enables want 0", en_count - en_before); end
    endtask

    task automatic test_reset_mid_store();
        int we_before;
        we_before  = we_count;
        mem[12]    = 32'h0000_0000;
        store_data = 32'h1234_5678;
        start_req(1'b1, 32'h0000_0030, 3'b010);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({ifc.Req_ready, ifc.Ram_en, ifc.Ram_we, ifc.Done, ifc.Err} !== 5'b10000) begin
            tests_failed++; $display("FAIL mrst_ctl got %b want 10000", {ifc.Req_ready, ifc.Ram_en, ifc.Ram_we, ifc.Done, ifc.Err});
        end
        tests_run++;
        if ({ifc.Ram_addr, ifc.Ram_wdata, ifc.Mc_addr_lo, ifc.Mc_type, ifc.Load_data} !== '0) begin
            tests_failed++; $display("FAIL mrst_data got addr=%h wd=%h lo=%h ty=%h ld=%h want all 0",
                ifc.Ram_addr, ifc.Ram_wdata, ifc.Mc_addr_lo, ifc.Mc_type, ifc.Load_data);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (ifc.Req_ready !== 1'b1 || we_count !== we_before || we_in_reset !== 0 || mem[12] !== 32'h0) begin
            tests_failed++; $display("FAIL mrst_after got ready=%b we_pulses=%0d we_in_rst=%0d mem=%h want 1 0 0 0",
                ifc.Req_ready, we_count - we_before, we_in_reset, mem[12]);
        end
    endtask

    task automatic test_back_to_back();
        mem[16]    = 32'h1122_3344;
        store_data = 32'h0000_005A;
        @(negedge clk);
        ifc.Req_valid = 1'b1;
        ifc.Req_write = 1'b1;
        ifc.Req_addr  = 32'h0000_0041;
        ifc.Req_type  = 3'b000;
        @(posedge clk);
        @(negedge clk);
        ifc.Req_write = 1'b0;
        ifc.Req_type  = 3'b100;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({ifc.Done, ifc.Ram_we, ifc.Req_ready} !== 3'b110 || ifc.Ram_wdata !== 32'h1122_5A44) begin
            tests_failed++; $display("FAIL b2b_store got done/we/ready=%b wd=%h want 110 11225a44",
                {ifc.Done, ifc.Ram_we, ifc.Req_ready}, ifc.Ram_wdata);
        end
        @(negedge clk);
        tests_run++;
        if ({ifc.Req_ready, ifc.Done, ifc.Ram_en} !== 3'b100) begin
            tests_failed++; $display("FAIL b2b_idle got ready/done/en=%b want 100", {ifc.Req_ready, ifc.Done, ifc.Ram_en});
        end
        @(negedge clk);
        ifc.Req_valid = 1'b0;
        tests_run++;
        if ({ifc.Req_ready, ifc.Ram_en, ifc.Ram_we} !== 3'b010) begin
            tests_failed++; $display("FAIL b2b_accept got ready/en/we=%b want 010", {ifc.Req_ready, ifc.Ram_en, ifc.Ram_we});
        end
        repeat (2) @(negedge clk);
        tests_run++;
        if (ifc.Done !== 1'b1 || ifc.Load_data !== 32'h0000_005A) begin
            tests_failed++; $display("FAIL b2b_load got done=%b ld=%h want 1 0000005a", ifc.Done, ifc.Load_data);
        end
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        en_count      = 0;
        we_count      = 0;
        we_in_reset   = 0;
        store_data    = '0;
        rst_n         = 1'b0;
        ifc.Req_valid = 1'b0;
        ifc.Req_write = 1'b0;
        ifc.Req_addr  = '0;
        ifc.Req_type  = '0;
        ifc.Ram_rdata = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_load_word();
        test_load_byte();
        test_store_half();
        test_reject();
        test_reset_mid_store();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
